// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one full-adder slice, LSB first
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             s;
    logic             c_next;
    logic [CW-1:0]    cnt;

    // The single full-adder slice; res_next drops the new bit in at the MSB
    // so that after WIDTH shifts the LSB-first stream lands in place.
    always_comb begin
        s        = sh_a[0] ^ sh_b[0] ^ carry;
        c_next   = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        res_next = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow, so invert b and cin here.
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= res_next;
                    carry <= c_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry here is the carry into the MSB, c_next the carry out.
                        sum      <= res_next;
                        cout     <= c_next;
                        overflow <= carry ^ c_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at WIDTH 8, 1 and 16
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        sub;
    logic        cin;
    logic [15:0] a_v;
    logic [15:0] b_v;
    logic        start8, start1, start16;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy1, done1, cout1, ovf1;
    logic [0:0]  sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int n_checks = 0;
    int n_fail   = 0;
    int which    = 8;

    logic        o_busy, o_done, o_cout, o_ovf;
    logic [15:0] o_sum;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a_v[7:0]), .b(b_v[7:0]),
        .cin(cin), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a_v[0:0]), .b(b_v[0:0]),
        .cin(cin), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a_v), .b(b_v),
        .cin(cin), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    always_comb begin
        o_busy = busy8;
        o_done = done8;
        o_sum  = {8'h00, sum8};
        o_cout = cout8;
        o_ovf  = ovf8;
        case (which)
            1: begin
                o_busy = busy1; o_done = done1; o_sum = {15'h0, sum1};
                o_cout = cout1; o_ovf = ovf1;
            end
            16: begin
                o_busy = busy16; o_done = done16; o_sum = sum16;
                o_cout = cout16; o_ovf = ovf16;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start1  = v;
            16:      start16 = v;
            default: start8  = v;
        endcase
    endtask

    // Reference: integer arithmetic on the operand values; returns {ovf, cout, sum}
    function automatic logic [17:0] model(input int w, input longint av, input longint bv,
                                          input longint ci, input logic su);
        longint m, r, sa, sb, sr;
        logic [15:0] s;
        logic c, o;
        m  = longint'(1) << w;
        r  = su ? (av - bv - ci) : (av + bv + ci);
        s  = 16'(r & (m - 1));
        c  = su ? (r >= 0) : (r >= m);
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        sr = su ? (sa - sb - ci) : (sa + sb + ci);
        o  = (sr < -(m / 2)) || (sr > (m / 2 - 1));
        return {o, c, s};
    endfunction

    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic su,
                          output logic [15:0] rs, output logic rc, output logic ro);
        int lat;
        which = w;
        a_v = av; b_v = bv; cin = ci; sub = su;
        set_start(w, 1'b1);
        cycle();
        set_start(w, 1'b0);
        a_v = 16'($urandom); b_v = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        chk($sformatf("w%0d busy_after_accept", w), 64'(o_busy), 64'd1);
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!o_done && lat < w + 4);
        chk($sformatf("w%0d done_latency", w), 64'(lat), 64'(w));
        chk($sformatf("w%0d busy_at_done", w), 64'(o_busy), 64'd0);
        rs = o_sum; rc = o_cout; ro = o_ovf;
        cycle();
        chk($sformatf("w%0d done_single_cycle", w), 64'(o_done), 64'd0);
    endtask

    task automatic check_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                               input logic ci, input logic su);
        logic [15:0] rs;
        logic rc, ro;
        logic [17:0] e;
        logic [15:0] mask;
        mask = 16'((longint'(1) << w) - 1);
        av = av & mask;
        bv = bv & mask;
        run_op(w, av, bv, ci, su, rs, rc, ro);
        e = model(w, longint'(av), longint'(bv), longint'(ci), su);
        chk($sformatf("w%0d a=%0h b=%0h cin=%0d sub=%0d result", w, av, bv, ci, su),
            {46'd0, ro, rc, rs}, {46'd0, e});
    endtask

    initial begin
        logic [15:0] rs;
        logic rc, ro;
        int ndone, first_i, last_i;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst = 1'b1; start8 = 0; start1 = 0; start16 = 0;
        a_v = 16'h0; b_v = 16'h0; cin = 0; sub = 0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("reset w8 outputs", {busy8, done8, cout8, ovf8, sum8}, 12'h0);
        chk("reset w1 outputs", {busy1, done1, cout1, ovf1, sum1}, 5'h0);
        chk("reset w16 outputs", {busy16, done16, cout16, ovf16, sum16}, 20'h0);

        foreach (vecs[i]) begin
            run_op(8, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, vecs[i].cin, vecs[i].sub, rs, rc, ro);
            chk($sformatf("vec%0d sum", i), 64'(rs), 64'(vecs[i].s));
            chk($sformatf("vec%0d cout", i), 64'(rc), 64'(vecs[i].c));
            chk($sformatf("vec%0d overflow", i), 64'(ro), 64'(vecs[i].o));
        end

        // start pulsed during RUN must be ignored
        which = 8;
        a_v = 16'h0F; b_v = 16'h01; cin = 0; sub = 0; start8 = 1;
        cycle();
        start8 = 0;
        cycle(); cycle();
        a_v = 16'h11; b_v = 16'h22; start8 = 1;
        cycle();
        start8 = 0;
        ndone = 0; rs = 16'hFFFF;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (done8) begin
                ndone++;
                rs = {8'h0, sum8};
            end
        end
        chk("ignored start done count", 64'(ndone), 64'd1);
        chk("ignored start sum", 64'(rs), 64'h10);

        // start held high: one op per WIDTH+2 cycles
        a_v = 16'h03; b_v = 16'h04; start8 = 1;
        ndone = 0; first_i = -1; last_i = -1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (done8) begin
                ndone++;
                if (first_i < 0) first_i = i;
                last_i = i;
                chk("held start sum", 64'(sum8), 64'h07);
            end
        end
        start8 = 0;
        chk("held start done count", 64'(ndone), 64'd3);
        chk("held start first done", 64'(first_i), 64'd9);
        chk("held start spacing", 64'(last_i - first_i), 64'd20);
        repeat (12) cycle();

        // reset on the 4th RUN edge aborts the op
        a_v = 16'h7F; b_v = 16'h01; cin = 0; sub = 0; start8 = 1;
        cycle();
        start8 = 0;
        repeat (3) cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("abort outputs cleared", {busy8, done8, cout8, ovf8, sum8}, 12'h0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (done8) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        run_op(8, 16'h03, 16'h04, 1'b0, 1'b0, rs, rc, ro);
        chk("after abort sum", {61'd0, ro, rc, rs[0]} | 64'(rs), 64'h07);

        // WIDTH=1 exhaustive
        for (int v = 0; v < 16; v++)
            check_model(1, 16'(v & 1), 16'((v >> 1) & 1), 1'((v >> 2) & 1), 1'((v >> 3) & 1));

        for (int i = 0; i < 200; i++)
            check_model(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        for (int i = 0; i < 1000; i++)
            check_model(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor built around a single full-adder slice and a carry register.
- Processes one operand bit per clock, LSB first. Produces a WIDTH-bit result with carry-out and signed overflow.
- Replaces per-width combinational adders in area-constrained datapaths.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b - cin), cin acts as borrow-in
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in (add) or borrow-in (sub); captured on the accepting edge
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result
- cout  output  1  final carry out; in sub mode 1 = no borrow, 0 = borrow
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset: synchronous, active-high. Applies on any edge with rst=1 and overrides start. Resulting values: state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, all internal shift/carry/count registers 0.
- Reset mid-operation aborts the operation; no done pulse is generated for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 on an edge: capture a into shift register A; capture (sub ? ~b : b) into shift register B.
  - Initialise carry = cin ^ sub, clear the bit counter, go to RUN, busy=1.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s = A[0]^B[0]^carry; carry <= majority(A[0], B[0], carry).
  - Shift s into the result MSB while shifting the result right; shift A and B right by 1; increment the counter.
  - On the edge where the counter reaches WIDTH-1 (the last bit): go to DONE, and register the final outputs.
  - Final outputs: cout = carry out of the MSB; overflow = carry into the MSB XOR carry out of the MSB; sum = the complete result.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally to IDLE. start is ignored in DONE.
- Latency:
  - Start accepted at edge k; bits are processed at edges k+1 .. k+WIDTH.
  - done is high during the cycle following edge k+WIDTH.
  - Minimum start-to-start period is WIDTH+2 cycles.
- start, a, b, cin, sub are ignored while in RUN or DONE; operands may change freely after the accepting edge.
- sum, cout, overflow:
  - Hold their last values from the DONE edge until the next completed operation.
  - Intermediate shifting is internal; the output registers update only on entry to DONE.
- WIDTH=1: a single RUN cycle; overflow = carry-in XOR carry-out of that bit.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=8 unless stated):
1. add a=0x0F b=0x01 cin=0, start at edge k -> busy high edges k..k+8; done high only in the cycle after edge k+8; sum=0x10, cout=0, overflow=0.
2. add a=0x7F b=0x01 cin=0 -> sum=0x80, cout=0, overflow=1. Then add a=0xFF b=0x01 cin=1 -> sum=0x01, cout=1, overflow=0.
3. sub a=0x05 b=0x07 cin=0 -> sum=0xFE, cout=0, overflow=0. Then sub a=0x80 b=0x01 cin=0 -> sum=0x7F, cout=1, overflow=1.
4. start pulsed with a=0x11 b=0x22 during RUN of the op 0x0F+0x01 -> ignored; result 0x10; exactly one done pulse. Then hold start=1 continuously -> ops accepted every 10 cycles, one done pulse per op.
5. rst asserted at the 4th RUN edge of 0x7F+0x01 -> next cycle busy=0, done=0, sum=0, cout=0, overflow=0; no done pulse follows. A subsequent start of 0x03+0x04 yields 0x07 with normal latency.
6. WIDTH=1 and WIDTH=16 builds -> sweep all (a, b, cin, sub) for WIDTH=1 and 1000 random vectors for WIDTH=16. Compare against a behavioural reference. Check done occurs exactly WIDTH edges after acceptance.
